// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: state encoding and adder-tree latency helper shared by the
// mat_mul scheduler and datapath.
package mat_mul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

   // ceil(log2(n)): depth of the datapath adder tree
   function automatic int lat_of(input int n);
      int l;
      l = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) l = i + 1;
      return l;
   endfunction

endpackage

// File: rtl/mat_mul_sched.sv
// mat_mul_sched: sequences tile-pair reads from A/B buffers into the mat_mul
// datapath, then waits out the adder-tree latency before signalling done.
module mat_mul_sched
   import mat_mul_pkg::*;
#(
   parameter int N      = 2,
   parameter int ADDR_W = 8,
   parameter int TILE_W = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic              abort,
   output logic              ready,
   output logic              rd_en,
   input  logic              rd_gnt,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic              mm_valid_in,
   output logic              mm_clear,
   output logic              done,
   output logic              err
);

   localparam int LAT  = lat_of(N);
   localparam int CNT_W = $clog2(LAT + 1) + 1;

   state_e              state_q, state_d;
   logic [TILE_W-1:0]   idx_q, idx_d;
   logic [TILE_W-1:0]   nt_q, nt_d;
   logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
   logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                rd_en_q, rd_en_d;
   logic                vld_q, vld_d;
   logic                clr_q, clr_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nt_d     = nt_q;
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      vld_d    = rd_en_q & rd_gnt;
      case (state_q)
         S_IDLE:
            if (start) begin
               if (num_tiles != '0) begin
                  state_d  = S_CLEAR;
                  nt_d     = num_tiles;
                  idx_d    = '0;
                  a_addr_d = a_base;
                  b_addr_d = b_base;
               end else begin
                  err_d = 1'b1;
               end
            end
         S_CLEAR: state_d = S_ISSUE;
         S_ISSUE:
            if (rd_gnt) begin
               if (idx_q == nt_q - TILE_W'(1)) begin
                  state_d = S_DRAIN;
                  cnt_d   = CNT_W'(LAT);
               end else begin
                  idx_d    = idx_q + TILE_W'(1);
                  a_addr_d = a_addr_q + ADDR_W'(1);
                  b_addr_d = b_addr_q + ADDR_W'(1);
               end
            end
         // LAT+1 cycles: counter runs LAT down to 0 inclusive
         S_DRAIN: begin
            state_d = (cnt_q == '0) ? S_DONE : S_DRAIN;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         idx_d   = '0;
         vld_d   = 1'b0;
      end
      ready_d = (state_d == S_IDLE);
      rd_en_d = (state_d == S_ISSUE);
      clr_d   = (state_d == S_CLEAR);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         nt_q     <= '0;
         a_addr_q <= '0;
         b_addr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rd_en_q  <= 1'b0;
         vld_q    <= 1'b0;
         clr_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nt_q     <= nt_d;
         a_addr_q <= a_addr_d;
         b_addr_q <= b_addr_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rd_en_q  <= rd_en_d;
         vld_q    <= vld_d;
         clr_q    <= clr_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign ready       = ready_q;
   assign rd_en       = rd_en_q;
   assign a_addr      = a_addr_q;
   assign b_addr      = b_addr_q;
   assign mm_valid_in = vld_q;
   assign mm_clear    = clr_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mat_mul_sched.sv
// tb_mat_mul_sched: job table with per-cycle expected outputs, an address
// scoreboard, plus hand-written abort and mid-job reset sequences.
module tb_mat_mul_sched;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [4:0] num_tiles = '0;
   logic [7:0] a_base = '0;
   logic [7:0] b_base = '0;
   logic       abort = 1'b0;
   logic       ready, rd_en, mm_valid_in, mm_clear, done, err;
   logic       rd_gnt = 1'b1;
   logic [7:0] a_addr, b_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  nt;
      logic [7:0]  ab;
      logic [7:0]  bb;
      logic [15:0] stall;
      logic        busy_start;
      logic        abort_start;
      int          exp_done;
      int          exp_err;
   } vec_t;

   vec_t vecs[8];
   logic [15:0] sb_q[$];

   mat_mul_sched #(.N(2), .ADDR_W(8), .TILE_W(5)) dut (
      .clk(clk), .resetn(resetn), .start(start), .num_tiles(num_tiles),
      .a_base(a_base), .b_base(b_base), .abort(abort), .ready(ready),
      .rd_en(rd_en), .rd_gnt(rd_gnt), .a_addr(a_addr), .b_addr(b_addr),
      .mm_valid_in(mm_valid_in), .mm_clear(mm_clear), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic stall_at(input logic [15:0] s, input int c);
      return (c < 16) ? s[c] : 1'b0;
   endfunction

   task automatic run_job(input int r);
      vec_t v;
      logic exp_rd[64];
      logic exp_vld[64];
      logic [7:0] ea, eb;
      logic [15:0] got_ab;
      logic [5:0] got_v, exp_v;
      int g, last;
      v = vecs[r];
      for (int i = 0; i < 64; i++) begin
         exp_rd[i] = 1'b0;
         exp_vld[i] = 1'b0;
      end
      g = 0;
      for (int c = 2; g < int'(v.nt) && c < 63; c++) begin
         exp_rd[c] = 1'b1;
         if (!stall_at(v.stall, c)) begin
            g++;
            exp_vld[c+1] = 1'b1;
         end
      end
      for (int i = 0; i < int'(v.nt); i++) begin
         ea = v.ab + 8'(i);
         eb = v.bb + 8'(i);
         sb_q.push_back({ea, eb});
      end
      chk($sformatf("row%0d ready_before", r), ready, 1);
      start = 1'b1;
      num_tiles = v.nt;
      a_base = v.ab;
      b_base = v.bb;
      abort = v.abort_start;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      last = (v.exp_done < 0) ? 4 : v.exp_done + 1;
      for (int c = 1; c <= last; c++) begin
         if (c > 1) cyc();
         rd_gnt = ~stall_at(v.stall, c);
         start = v.busy_start && c >= 2 && c <= 5;
         num_tiles = start ? 5'd0 : v.nt;
         got_v = {ready, rd_en, mm_valid_in, mm_clear, done, err};
         exp_v = {(v.nt == 0) || c > v.exp_done, exp_rd[c], exp_vld[c],
                  (v.nt != 0) && c == 1, c == v.exp_done, c == v.exp_err};
         chk($sformatf("row%0d c%0d rdy/rd/vld/clr/done/err", r, c), got_v, exp_v);
         if (rd_en && rd_gnt) begin
            got_ab = {a_addr, b_addr};
            if (sb_q.size() == 0) chk($sformatf("row%0d c%0d extra_read", r, c), got_ab, 16'hxxxx);
            else chk($sformatf("row%0d c%0d addr", r, c), got_ab, sb_q.pop_front());
         end
      end
      start = 1'b0;
      rd_gnt = 1'b1;
      chk($sformatf("row%0d sb_empty", r), sb_q.size(), 0);
      sb_q.delete();
   endtask

   initial begin
      logic seen;
      vecs[0] = '{5'd4,  8'h10, 8'h20, 16'h0000, 1'b0, 1'b0, 8,  -1};
      vecs[1] = '{5'd4,  8'h10, 8'h20, 16'h0018, 1'b0, 1'b0, 10, -1};
      vecs[2] = '{5'd3,  8'hFE, 8'h05, 16'h0000, 1'b0, 1'b0, 7,  -1};
      vecs[3] = '{5'd0,  8'h33, 8'h44, 16'h0000, 1'b0, 1'b0, -1, 1};
      vecs[4] = '{5'd1,  8'h40, 8'h50, 16'h0000, 1'b1, 1'b0, 5,  -1};
      vecs[5] = '{5'd2,  8'h00, 8'hFF, 16'h000C, 1'b0, 1'b0, 8,  -1};
      vecs[6] = '{5'd5,  8'h80, 8'h81, 16'h0000, 1'b0, 1'b1, 9,  -1};
      vecs[7] = '{5'd31, 8'hF0, 8'h00, 16'h0000, 1'b0, 1'b0, 35, -1};

      #12;
      chk("reset outs", {ready, rd_en, mm_valid_in, mm_clear, done, err, a_addr, b_addr},
          {6'b100000, 16'h0000});
      resetn = 1'b1;
      cyc();

      for (int r = 0; r < 8; r++) run_job(r);

      // abort during ISSUE cycle 4
      start = 1'b1; num_tiles = 5'd4; a_base = 8'h10; b_base = 8'h20; rd_gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc(); cyc(); cyc();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort c5 rdy/rd/vld/done", {ready, rd_en, mm_valid_in, done}, 4'b1000);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         seen |= done | rd_en | mm_valid_in;
      end
      chk("abort no activity after", seen, 0);
      run_job(0);

      // asynchronous reset while in DRAIN (cycle 6)
      start = 1'b1; num_tiles = 5'd4; a_base = 8'h10; b_base = 8'h20;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk("drain c6 rd/vld/rdy", {rd_en, mm_valid_in, ready}, 3'b010);
      #2 resetn = 1'b0;
      #1;
      chk("async reset outs", {ready, rd_en, mm_valid_in, mm_clear, done, err, a_addr, b_addr},
          {6'b100000, 16'h0000});
      #2 resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         seen |= done | ~ready;
      end
      chk("post reset no done", seen, 0);
      run_job(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
